// File: rtl/spike_flit_serializer_if.sv
// Neuron-to-router transmit port: packet push side, flit write side and status.
interface spike_flit_serializer_if #(
    parameter int PACKET_SIZE    = 32,
    parameter int FLIT_SIZE      = 4,
    parameter int DROP_CNT_WIDTH = 16
) ();
    logic [PACKET_SIZE-1:0]    packet_in;
    logic                      packet_write_req;
    logic                      packet_full;
    logic                      router_full;
    logic [FLIT_SIZE-1:0]      flit_out;
    logic                      write_req;
    logic                      busy;
    logic [DROP_CNT_WIDTH-1:0] drop_count;

    modport master (
        output packet_in, packet_write_req, router_full,
        input  packet_full, flit_out, write_req, busy, drop_count
    );

    modport slave (
        input  packet_in, packet_write_req, router_full,
        output packet_full, flit_out, write_req, busy, drop_count
    );
endinterface

// File: rtl/spike_flit_serializer.sv
// Buffers spike packets in a small FIFO and streams them to the router local
// input as FLIT_SIZE-bit flits, most significant flit first, under router_full.
module spike_flit_serializer #(
    parameter int PACKET_SIZE     = 32,
    parameter int FLIT_SIZE       = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int FIFO_ADDR_WIDTH = 2,
    parameter int DROP_CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    spike_flit_serializer_if.slave bus
);
    localparam int NF    = PACKET_SIZE / FLIT_SIZE;
    localparam int IDX_W = (NF > 1) ? $clog2(NF) : 1;
    localparam int CNT_W = FIFO_ADDR_WIDTH + 1;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

    state_e                                   state_q, state_d;
    logic [FIFO_DEPTH-1:0][PACKET_SIZE-1:0]   mem_q, mem_d;
    logic [FIFO_ADDR_WIDTH-1:0]               rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_WIDTH-1:0]               wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]                         count_q, count_d;
    logic [PACKET_SIZE-1:0]                   shift_reg_q, shift_reg_d;
    logic [IDX_W-1:0]                         flit_idx_q, flit_idx_d;
    logic [FLIT_SIZE-1:0]                     flit_out_q, flit_out_d;
    logic                                     write_req_q, write_req_d;
    logic [DROP_CNT_WIDTH-1:0]                drop_count_q, drop_count_d;

    logic fifo_full, fifo_empty, push, pop, issue, last_flit;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = bus.packet_write_req && !fifo_full;
    assign issue      = (state_q == SEND) && !bus.router_full;
    assign last_flit  = issue && (flit_idx_q == IDX_W'(NF - 1));
    // Refill on the last flit's edge keeps back-to-back packets gap-free.
    assign pop        = !fifo_empty && ((state_q == IDLE) || last_flit);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = SEND;
            SEND:    if (last_flit && fifo_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_reg_d = shift_reg_q;
        flit_idx_d  = flit_idx_q;
        flit_out_d  = flit_out_q;
        write_req_d = 1'b0;
        if (issue) begin
            write_req_d = 1'b1;
            flit_out_d  = shift_reg_q[PACKET_SIZE-1 -: FLIT_SIZE];
            shift_reg_d = shift_reg_q << FLIT_SIZE;
            flit_idx_d  = flit_idx_q + IDX_W'(1);
        end
        if (pop) begin
            shift_reg_d = mem_q[rd_ptr_q];
            flit_idx_d  = '0;
        end
    end

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        drop_count_d = drop_count_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.packet_in;
            wr_ptr_d        = wr_ptr_q + FIFO_ADDR_WIDTH'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + FIFO_ADDR_WIDTH'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Judged on the registered full flag, so a same-edge pop does not save it.
        if (bus.packet_write_req && fifo_full && (drop_count_q != '1))
            drop_count_d = drop_count_q + DROP_CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            shift_reg_q  <= '0;
            flit_idx_q   <= '0;
            flit_out_q   <= '0;
            write_req_q  <= 1'b0;
            drop_count_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            shift_reg_q  <= shift_reg_d;
            flit_idx_q   <= flit_idx_d;
            flit_out_q   <= flit_out_d;
            write_req_q  <= write_req_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.packet_full = fifo_full;
    assign bus.flit_out    = flit_out_q;
    assign bus.write_req   = write_req_q;
    assign bus.busy        = !fifo_empty || (state_q == SEND);
    assign bus.drop_count  = drop_count_q;
endmodule

// File: tb/tb_spike_flit_serializer.sv
// Directed and random stimulus against a queue-based model of the serializer.
module tb_spike_flit_serializer;
    localparam int PS = 32;
    localparam int FS = 4;
    localparam int DEPTH = 4;
    localparam int NF = PS / FS;

    logic clk;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    spike_flit_serializer_if #(.PACKET_SIZE(PS), .FLIT_SIZE(FS), .DROP_CNT_WIDTH(16)) bus ();

    spike_flit_serializer #(
        .PACKET_SIZE(PS), .FLIT_SIZE(FS), .FIFO_DEPTH(DEPTH),
        .FIFO_ADDR_WIDTH(2), .DROP_CNT_WIDTH(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: queued packets, flits left of the packet in flight, last outputs.
    logic [PS-1:0] m_q[$];
    logic [FS-1:0] m_cur[$];
    logic [FS-1:0] m_flit;
    logic          m_wr;
    logic [15:0]   m_drop;

    logic [FS-1:0] got[$];
    int            run_len;
    int            max_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_load();
        logic [PS-1:0] p;
        p = m_q.pop_front();
        for (int i = 0; i < NF; i++) m_cur.push_back(FS'(p >> (PS - FS - FS * i)));
    endtask

    task automatic model_edge(input logic rst, input logic req, input logic [PS-1:0] pkt, input logic rf);
        logic was_full;
        if (rst) begin
            m_q.delete();
            m_cur.delete();
            m_flit = '0;
            m_wr   = 1'b0;
            m_drop = '0;
            return;
        end
        was_full = (m_q.size() == DEPTH);
        m_wr = 1'b0;
        if (m_cur.size() != 0) begin
            if (!rf) begin
                m_wr   = 1'b1;
                m_flit = m_cur.pop_front();
                if (m_cur.size() == 0 && m_q.size() != 0) model_load();
            end
        end else if (m_q.size() != 0) begin
            model_load();
        end
        if (req) begin
            if (!was_full) m_q.push_back(pkt);
            else if (m_drop != 16'hFFFF) m_drop++;
        end
    endtask

    task automatic step(input logic rst, input logic req, input logic [PS-1:0] pkt, input logic rf);
        reset                = rst;
        bus.packet_write_req = req;
        bus.packet_in        = pkt;
        bus.router_full      = rf;
        @(posedge clk);
        model_edge(rst, req, pkt, rf);
        #1;
        chk("write_req",   32'(bus.write_req),   32'(m_wr));
        chk("flit_out",    32'(bus.flit_out),    32'(m_flit));
        chk("packet_full", 32'(bus.packet_full), 32'(m_q.size() == DEPTH));
        chk("busy",        32'(bus.busy),        32'(m_q.size() != 0 || m_cur.size() != 0));
        chk("drop_count",  32'(bus.drop_count),  32'(m_drop));
        if (bus.write_req) begin
            got.push_back(bus.flit_out);
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    endtask

    function automatic logic [31:0] pack_got(input int first);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < NF; i++)
            if (first + i < got.size()) v = {v[27:0], got[first + i]};
        return v;
    endfunction

    task automatic restart();
        step(1'b1, 1'b0, '0, 1'b0);
        got.delete();
        run_len = 0;
        max_run = 0;
    endtask

    initial begin
        m_flit = '0; m_wr = 1'b0; m_drop = '0;
        run_len = 0; max_run = 0;
        reset = 1'b1;
        bus.packet_write_req = 1'b0;
        bus.packet_in = '0;
        bus.router_full = 1'b0;

        // Reset state
        restart();
        restart();
        chk("rst_write_req", 32'(bus.write_req), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);

        // 1: single packet, no backpressure
        step(1'b0, 1'b1, 32'hA5C31E7F, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t1_no_flit_at_e1", 32'(bus.write_req), 32'd0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 1'b0);
        chk("t1_flit_count", 32'(got.size()), 32'd8);
        chk("t1_flits", pack_got(0), 32'hA5C31E7F);
        chk("t1_run", 32'(max_run), 32'd8);
        chk("t1_busy_end", 32'(bus.busy), 32'd0);

        // 2: three stalled edges after the second flit
        restart();
        step(1'b0, 1'b1, 32'hA5C31E7F, 1'b0);
        for (int i = 0; i < 20 && got.size() < 2; i++) step(1'b0, 1'b0, '0, 1'b0);
        chk("t2_two_flits", 32'(got.size()), 32'd2);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            chk("t2_stall_wr", 32'(bus.write_req), 32'd0);
            chk("t2_stall_flit", 32'(bus.flit_out), 32'h5);
        end
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 1'b0);
        chk("t2_flit_count", 32'(got.size()), 32'd8);
        chk("t2_flits", pack_got(0), 32'hA5C31E7F);

        // 3: back-to-back packets stream without a gap
        restart();
        step(1'b0, 1'b1, 32'h12345678, 1'b0);
        step(1'b0, 1'b1, 32'h9ABCDEF0, 1'b0);
        for (int i = 0; i < 22; i++) step(1'b0, 1'b0, '0, 1'b0);
        chk("t3_flit_count", 32'(got.size()), 32'd16);
        chk("t3_run", 32'(max_run), 32'd16);
        chk("t3_pkt0", pack_got(0), 32'h12345678);
        chk("t3_pkt1", pack_got(8), 32'h9ABCDEF0);

        // 4: overflow with the router blocked
        restart();
        for (int k = 1; k <= 6; k++) step(1'b0, 1'b1, 32'h11111111 * k, 1'b1);
        chk("t4_full", 32'(bus.packet_full), 32'd1);
        chk("t4_drop", 32'(bus.drop_count), 32'd1);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0, '0, 1'b0);
        chk("t4_flit_count", 32'(got.size()), 32'd40);
        chk("t4_first", pack_got(0), 32'h11111111);
        chk("t4_last", pack_got(32), 32'h55555555);

        // 5: reset mid-packet with another packet queued
        restart();
        step(1'b0, 1'b1, 32'hCAFEF00D, 1'b0);
        step(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        for (int i = 0; i < 20 && got.size() < 3; i++) step(1'b0, 1'b0, '0, 1'b0);
        chk("t5_three_flits", 32'(got.size()), 32'd3);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("t5_rst_wr", 32'(bus.write_req), 32'd0);
        chk("t5_rst_flit", 32'(bus.flit_out), 32'd0);
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        chk("t5_rst_full", 32'(bus.packet_full), 32'd0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 1'b0);
        chk("t5_no_more_flits", 32'(got.size()), 32'd3);

        // 6: full FIFO, pop and rejected push on the same edge
        restart();
        for (int k = 1; k <= 5; k++) step(1'b0, 1'b1, 32'h01010101 * k, 1'b1);
        chk("t6_full", 32'(bus.packet_full), 32'd1);
        for (int i = 0; i < 20 && m_cur.size() > 1; i++) step(1'b0, 1'b0, '0, 1'b0);
        chk("t6_one_left", 32'(m_cur.size()), 32'd1);
        step(1'b0, 1'b1, 32'h77777777, 1'b0);
        chk("t6_drop", 32'(bus.drop_count), 32'd1);
        chk("t6_not_full", 32'(bus.packet_full), 32'd0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, '0, 1'b0);
        chk("t6_flit_count", 32'(got.size()), 32'd40);

        // Random traffic, backpressure and occasional reset
        restart();
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 99) < 35),
                 $urandom(),
                 ($urandom_range(0, 99) < 30));
        end
        for (int i = 0; i < 60; i++) step(1'b0, 1'b0, '0, 1'b0);
        chk("rand_drained", 32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
